// File: rtl/dot_product_accumulator.sv
// Accumulates the product stream of a fixed-latency multiplier into one dot product per operand vector.
// Finished elements wait in a 2-entry output queue, because the multiplier cannot be stalled.
module dot_product_accumulator #(
    parameter int MUL_LATENCY = 6,
    parameter int PROD_W      = 32,
    parameter int ACC_W       = 40,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] product,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy,
    output logic              drop_err
);

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } entry_t;

    logic [MUL_LATENCY-1:0] v_q, v_d, l_q, l_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   first_q, first_d;
    entry_t                 head_q, head_d, tail_q, tail_d;
    logic                   head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic                   drop_q, drop_d;
    logic                   busy_q, busy_d;

    logic                   pv_s, plast_s, push_s, pop_s;
    logic [ACC_W-1:0]       prod_ext_s, acc_base_s;
    logic [ACC_W:0]         add_s;
    entry_t                 new_s;

    assign pv_s       = v_q[MUL_LATENCY-1];
    assign plast_s    = l_q[MUL_LATENCY-1];
    assign prod_ext_s = ACC_W'(product);
    // The first term of an element adds to zero, so no stale carry can leak in.
    assign acc_base_s = first_q ? {ACC_W{1'b0}} : acc_q;
    assign add_s      = {1'b0, acc_base_s} + {1'b0, prod_ext_s};

    // Tag delay line, accumulation datapath and per-element bookkeeping.
    always_comb begin
        v_d     = v_q;
        l_d     = l_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        first_d = first_q;
        for (int i = MUL_LATENCY-1; i > 0; i--) begin
            v_d[i] = v_q[i-1];
            l_d[i] = l_q[i-1];
        end
        v_d[0] = in_valid;
        l_d[0] = in_valid & in_last;

        new_s.data = add_s[ACC_W-1:0];
        if (first_q) begin
            new_s.cnt = CNT_W'(1);
            new_s.ovf = add_s[ACC_W];
        end else begin
            new_s.cnt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            new_s.ovf = ovf_q | add_s[ACC_W];
        end

        push_s = pv_s & plast_s;
        if (pv_s && !plast_s) begin
            acc_d   = new_s.data;
            cnt_d   = new_s.cnt;
            ovf_d   = new_s.ovf;
            first_d = 1'b0;
        end else if (push_s) begin
            first_d = 1'b1;
        end else begin
            first_d = first_q;
        end
        busy_d = (|v_d) | ~first_d;
    end

    // Output queue: pop first so a full queue can accept a push in the same cycle.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        drop_d     = drop_q;
        pop_s      = head_vld_q & out_ready;
        if (pop_s) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end else begin
            head_vld_d = head_vld_q;
        end
        if (push_s) begin
            if (!head_vld_d) begin
                head_d     = new_s;
                head_vld_d = 1'b1;
            end else if (!tail_vld_d) begin
                tail_d     = new_s;
                tail_vld_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else begin
            drop_d = drop_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q        <= {MUL_LATENCY{1'b0}};
            l_q        <= {MUL_LATENCY{1'b0}};
            acc_q      <= {ACC_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
            first_q    <= 1'b1;
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            drop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            v_q        <= v_d;
            l_q        <= l_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            first_q    <= first_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            drop_q     <= drop_d;
            busy_q     <= busy_d;
        end
    end

    assign out_valid = head_vld_q;
    assign out_data  = head_q.data;
    assign out_count = head_q.cnt;
    assign out_ovf   = head_q.ovf;
    assign busy      = busy_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench: directed and random operand streams drive two accumulators (40- and 33-bit)
// behind a modelled 6-cycle multiplier; a monitor checks every cycle against a queue-level reference.
module tb_dot_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] product;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [31:0] tv = 32'd0;
    logic [31:0] mpipe [6];

    logic        out_valid_a, out_ovf_a, busy_a, drop_err_a;
    logic [39:0] out_data_a;
    logic [15:0] out_count_a;
    logic        out_valid_b, out_ovf_b, busy_b, drop_err_b;
    logic [32:0] out_data_b;
    logic [15:0] out_count_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic [63:0] sum; int n; int done; } elem_t;
    typedef struct { int c; logic last; } issue_t;
    elem_t  pending[$];
    elem_t  mq[$];
    issue_t log_q[$];
    logic   exp_drop = 1'b0;
    logic [63:0] cur_sum = 64'd0;
    int     cur_n = 0;

    always #5 clk = ~clk;

    // Behavioural 6-cycle multiplier: the bench supplies each term's product directly.
    always @(posedge clk) begin
        mpipe[0] <= tv;
        for (int i = 1; i < 6; i++) mpipe[i] <= mpipe[i-1];
        cyc <= cyc + 1;
    end
    assign product = mpipe[5];

    dot_product_accumulator #(.MUL_LATENCY(6), .PROD_W(32), .ACC_W(40), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .product(product), .in_valid(in_valid), .in_last(in_last),
        .out_ready(out_ready), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_count(out_count_a), .out_ovf(out_ovf_a), .busy(busy_a), .drop_err(drop_err_a));

    dot_product_accumulator #(.MUL_LATENCY(6), .PROD_W(32), .ACC_W(33), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .product(product), .in_valid(in_valid), .in_last(in_last),
        .out_ready(out_ready), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_count(out_count_b), .out_ovf(out_ovf_b), .busy(busy_b), .drop_err(drop_err_b));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%h want=%h", nm, cyc, got, exp);
        end
    endtask

    // Busy while any term is within its 6-cycle flight, or the latest landed term left an element open.
    function automatic logic exp_busy(int k);
        for (int i = log_q.size() - 1; i >= 0; i--) begin
            if (log_q[i].c <= k - 1 && log_q[i].c >= k - 6) return 1'b1;
            if (log_q[i].c <= k - 7) return !log_q[i].last;
        end
        return 1'b0;
    endfunction

    // Monitor: compare this cycle's outputs, then advance the queue model across the next edge.
    always @(negedge clk) begin
        logic eb, pop, push;
        elem_t e;
        #2;
        eb = exp_busy(cyc);
        chk("valid_a", {63'd0, out_valid_a}, {63'd0, mq.size() != 0});
        chk("valid_b", {63'd0, out_valid_b}, {63'd0, mq.size() != 0});
        chk("drop_a", {63'd0, drop_err_a}, {63'd0, exp_drop});
        chk("drop_b", {63'd0, drop_err_b}, {63'd0, exp_drop});
        chk("busy_a", {63'd0, busy_a}, {63'd0, eb});
        chk("busy_b", {63'd0, busy_b}, {63'd0, eb});
        if (mq.size() != 0) begin
            e = mq[0];
            chk("data_a", {24'd0, out_data_a}, {24'd0, e.sum[39:0]});
            chk("ovf_a", {63'd0, out_ovf_a}, {63'd0, |e.sum[63:40]});
            chk("data_b", {31'd0, out_data_b}, {31'd0, e.sum[32:0]});
            chk("ovf_b", {63'd0, out_ovf_b}, {63'd0, |e.sum[63:33]});
            chk("count_a", {48'd0, out_count_a}, (e.n > 65535) ? 64'd65535 : 64'(e.n));
            chk("count_b", {48'd0, out_count_b}, (e.n > 65535) ? 64'd65535 : 64'(e.n));
        end
        if (rst) begin
            mq.delete();
            pending.delete();
            log_q.delete();
            exp_drop = 1'b0;
        end else begin
            pop  = (mq.size() != 0) && out_ready;
            push = (pending.size() != 0) && (pending[0].done == cyc + 1);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e = pending.pop_front();
                if (mq.size() < 2) mq.push_back(e);
                else exp_drop = 1'b1;
            end
            while (log_q.size() > 64) void'(log_q.pop_front());
        end
    end

    task automatic step(input logic v, input logic l, input logic [31:0] p, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        tv        = p;
        out_ready = r;
        if (v) begin
            log_q.push_back('{cyc, l});
            cur_sum = cur_sum + 64'(p);
            cur_n++;
            if (l) begin
                pending.push_back('{cur_sum, cur_n, cyc + 7});
                cur_sum = 64'd0;
                cur_n   = 0;
            end
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, r);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        cur_sum = 64'd0; cur_n = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", {63'd0, out_valid_a | out_valid_b}, 64'd0);
        chk("rst_data_a", {24'd0, out_data_a}, 64'd0);
        chk("rst_data_b", {31'd0, out_data_b}, 64'd0);
        chk("rst_count", {32'd0, out_count_a, out_count_b}, 64'd0);
        chk("rst_flags", {60'd0, out_ovf_a, out_ovf_b, busy_a | busy_b, drop_err_a | drop_err_b}, 64'd0);
    endtask

    initial begin
        int len;
        rst_pulse();
        // Basic {1,2,3,4}.{5,6,7,8}
        step(1'b1, 1'b0, 32'd5, 1'b1);
        step(1'b1, 1'b0, 32'd12, 1'b1);
        step(1'b1, 1'b0, 32'd21, 1'b1);
        step(1'b1, 1'b1, 32'd32, 1'b1);
        idle(10, 1'b1);
        // Single term, then a restart with 2 + 3
        step(1'b1, 1'b1, 32'hFFFE_0001, 1'b1);
        step(1'b1, 1'b0, 32'd2, 1'b1);
        step(1'b1, 1'b1, 32'd3, 1'b1);
        idle(10, 1'b1);
        // Overflow on the 33-bit instance, then a clean two-term element
        step(1'b1, 1'b0, 32'hFFFE_0001, 1'b1);
        step(1'b1, 1'b0, 32'hFFFE_0001, 1'b1);
        step(1'b1, 1'b1, 32'hFFFE_0001, 1'b1);
        step(1'b1, 1'b0, 32'hFFFE_0001, 1'b1);
        step(1'b1, 1'b1, 32'hFFFE_0001, 1'b1);
        idle(10, 1'b1);
        // Backpressure: 9 is dropped
        step(1'b1, 1'b1, 32'd7, 1'b0);
        step(1'b1, 1'b1, 32'd8, 1'b0);
        step(1'b1, 1'b1, 32'd9, 1'b0);
        idle(12, 1'b0);
        idle(6, 1'b1);
        rst_pulse();
        // Full queue: pop and push coincide when 9 lands
        step(1'b1, 1'b1, 32'd7, 1'b0);
        step(1'b1, 1'b1, 32'd8, 1'b0);
        step(1'b1, 1'b1, 32'd9, 1'b0);
        idle(5, 1'b0);
        idle(8, 1'b1);
        // Reset with a partial element and products still in flight
        step(1'b1, 1'b0, 32'd10, 1'b1);
        step(1'b1, 1'b0, 32'd20, 1'b1);
        idle(1, 1'b1);
        rst_pulse();
        step(1'b1, 1'b1, 32'd4, 1'b1);
        idle(10, 1'b1);
        // Long all-ones element overflows the 40-bit accumulator
        for (int t = 0; t < 300; t++) step(1'b1, t == 299, 32'hFFFF_FFFF, 1'b1);
        idle(10, 1'b1);
        // Random elements, gaps with stray in_last, random backpressure
        for (int e = 0; e < 200; e++) begin
            len = $urandom_range(1, 6);
            for (int t = 0; t < len; t++) begin
                step(1'b1, t == len - 1, $urandom, $urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0);
            end
        end
        // Drain with a bounded wait
        begin
            int guard = 0;
            while ((pending.size() != 0 || mq.size() != 0) && guard < 100) begin
                idle(1, 1'b1);
                guard++;
            end
            chk("drain_timeout", {63'd0, guard < 100}, 64'd1);
        end
        idle(2, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
